// File: rtl/enigma_pkg.sv
// Shared Enigma constants: alphabet size, wheel/reflector wiring, notches,
// mod-26 helpers and the scrambler FSM state type.
package enigma_pkg;

  localparam int unsigned ALPHA      = 26;
  localparam int unsigned CW         = 5;
  localparam logic [5:0]  ALPHA6     = 6'(ALPHA);

  typedef logic [CW-1:0]                 char_t;
  typedef logic [ALPHA-1:0][CW-1:0]      table_t;
  typedef enum logic [2:0] {IDLE, FWD, REFL, BWD, DONE} state_t;

  // Convert a 26-letter wiring string ("EKMF...") into a 5-bit lookup table.
  function automatic table_t to_table(input logic [8*ALPHA-1:0] s);
    table_t t;
    for (int i = 0; i < int'(ALPHA); i++)
      t[i] = CW'(s[8*(int'(ALPHA)-1-i) +: 8] - 8'd65);
    return t;
  endfunction

  // Inverse permutation, used on the return path through the wheels.
  function automatic table_t invert(input table_t f);
    table_t t;
    t = '0;
    for (int i = 0; i < int'(ALPHA); i++)
      t[f[i]] = CW'(i);
    return t;
  endfunction

  localparam table_t WHEEL_I       = to_table("EKMFLGDQVZNTOWYHXUSPAIBRCJ");
  localparam table_t WHEEL_II      = to_table("AJDKSIRUXBLHWTMCQGZNPYFVOE");
  localparam table_t WHEEL_III     = to_table("BDFHJLCPRTXVZNYEIWGAKMUSQO");
  localparam table_t WHEEL_IV      = to_table("ESOVPZJAYQUIRHXLNFTGKDCMWB");
  localparam table_t WHEEL_V       = to_table("VZBRGITYUPSDNHLXAWMJQOFECK");
  localparam table_t WHEEL_I_INV   = invert(WHEEL_I);
  localparam table_t WHEEL_II_INV  = invert(WHEEL_II);
  localparam table_t WHEEL_III_INV = invert(WHEEL_III);
  localparam table_t WHEEL_IV_INV  = invert(WHEEL_IV);
  localparam table_t WHEEL_V_INV   = invert(WHEEL_V);
  localparam table_t REFLECTOR_B   = to_table("YRUHQSLDPXNGOKMIEBFZCWVJAT");

  // Unknown wheel IDs (5..7) behave as wheel I.
  function automatic char_t notch(input logic [2:0] id);
    case (id)
      3'd1:    return 5'd4;
      3'd2:    return 5'd21;
      3'd3:    return 5'd9;
      3'd4:    return 5'd25;
      default: return 5'd16;
    endcase
  endfunction

  function automatic char_t wheel_lut(input logic [2:0] id, input logic inv, input char_t idx);
    table_t t;
    case (id)
      3'd1:    t = inv ? WHEEL_II_INV  : WHEEL_II;
      3'd2:    t = inv ? WHEEL_III_INV : WHEEL_III;
      3'd3:    t = inv ? WHEEL_IV_INV  : WHEEL_IV;
      3'd4:    t = inv ? WHEEL_V_INV   : WHEEL_V;
      default: t = inv ? WHEEL_I_INV   : WHEEL_I;
    endcase
    return (idx < 5'd26) ? t[idx] : idx;
  endfunction

  function automatic char_t reflect_b(input char_t c);
    return (c < 5'd26) ? REFLECTOR_B[c] : c;
  endfunction

  function automatic char_t add_mod(input char_t a, input char_t b);
    logic [5:0] s;
    s = 6'(a) + 6'(b);
    if (s >= ALPHA6) s = s - ALPHA6;
    return s[CW-1:0];
  endfunction

  function automatic char_t sub_mod(input char_t a, input char_t b);
    logic [5:0] s;
    s = 6'(a) - 6'(b);
    if (a < b) s = s + ALPHA6;
    return s[CW-1:0];
  endfunction

endpackage

// File: rtl/enigma_rotor_stack_if.sv
// Letter handshake bundle: input channel (in_valid/in_ready/in_char) and
// output channel (out_valid/out_ready/out_char).
// master = letter producer/consumer side, slave = scrambler side.
interface enigma_rotor_stack_if;
  import enigma_pkg::*;

  logic  in_valid;
  logic  in_ready;
  char_t in_char;
  logic  out_valid;
  logic  out_ready;
  char_t out_char;

  modport master (output in_valid, in_char, out_ready,
                  input  in_ready, out_valid, out_char);
  modport slave  (input  in_valid, in_char, out_ready,
                  output in_ready, out_valid, out_char);
endinterface

// File: rtl/enigma_wheel_map.sv
// One wheel pass: ch_out_c = (W[(ch+pos) mod 26] - pos) mod 26, with W the
// forward table (dir=0) or its inverse (dir=1) of wheel wheel_id.
// Ports: ch, pos, wheel_id, dir in; ch_out_c out (combinational).
module enigma_wheel_map
  import enigma_pkg::*;
(
  input  char_t      ch,
  input  char_t      pos,
  input  logic [2:0] wheel_id,
  input  logic       dir,
  output char_t      ch_out_c
);

  char_t idx_c;
  char_t mapped_c;

  always_comb begin
    idx_c    = add_mod(ch, pos);
    mapped_c = wheel_lut(wheel_id, dir, idx_c);
    ch_out_c = sub_mod(mapped_c, pos);
  end

endmodule

// File: rtl/enigma_rotor_stack.sv
// Clocked Enigma scrambler: odometer stepping with double-step on accept,
// then one wheel per cycle forward, reflector B, one wheel per cycle back.
// Ports: clk, rst (sync, active-high), load_en/load_pos (position load in
// IDLE), rotor_pos (current positions), io (letter handshakes, slave side).
module enigma_rotor_stack
  import enigma_pkg::*;
#(
  parameter int unsigned             NUM_ROTORS  = 3,
  parameter logic [3*NUM_ROTORS-1:0] WHEEL_ORDER = 9'b000_001_010
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic [5*NUM_ROTORS-1:0] load_pos,
  output logic [5*NUM_ROTORS-1:0] rotor_pos,
  enigma_rotor_stack_if.slave     io
);

  localparam int unsigned   KW     = 3;
  localparam logic [KW-1:0] K_LAST = KW'(NUM_ROTORS - 1);

  state_t                  state_q, state_d;
  logic [KW-1:0]           k_q;
  char_t                   x_q;
  char_t                   out_char_q;
  logic                    out_valid_q;
  logic                    bypass_q;
  logic [5*NUM_ROTORS-1:0] pos_q;
  logic [5*NUM_ROTORS-1:0] pos_step_c;
  logic [5*NUM_ROTORS-1:0] pos_load_c;
  logic                    in_ready_c;
  logic                    nonletter_c;
  char_t                   map_pos_c;
  char_t                   map_out_c;
  logic [2:0]              map_id_c;

  assign io.in_ready  = in_ready_c;
  assign io.out_valid = out_valid_q;
  assign io.out_char  = out_char_q;
  assign rotor_pos    = pos_q;
  assign nonletter_c  = (io.in_char > 5'd25);

  // Post-step positions from the pre-step ones; middle rotors double-step.
  always_comb begin
    logic [NUM_ROTORS-1:0] at_notch;
    logic [NUM_ROTORS-1:0] step;
    at_notch   = '0;
    step       = '0;
    pos_step_c = pos_q;
    pos_load_c = '0;
    for (int i = 0; i < int'(NUM_ROTORS); i++)
      at_notch[i] = (pos_q[5*i +: 5] == notch(WHEEL_ORDER[3*i +: 3]));
    step[0] = 1'b1;
    for (int i = 1; i < int'(NUM_ROTORS); i++)
      step[i] = at_notch[i-1] | ((i < int'(NUM_ROTORS) - 1) ? at_notch[i] : 1'b0);
    for (int i = 0; i < int'(NUM_ROTORS); i++) begin
      if (step[i])
        pos_step_c[5*i +: 5] = (pos_q[5*i +: 5] == 5'd25) ? 5'd0 : pos_q[5*i +: 5] + 5'd1;
      pos_load_c[5*i +: 5] = (load_pos[5*i +: 5] > 5'd25) ? load_pos[5*i +: 5] - 5'd26
                                                          : load_pos[5*i +: 5];
    end
  end

  // The single wheel mapper is steered by the stage index k.
  always_comb begin
    map_pos_c = pos_q[5*int'(k_q) +: 5];
    map_id_c  = WHEEL_ORDER[3*int'(k_q) +: 3];
  end

  enigma_wheel_map u_wheel_map (
    .ch       (x_q),
    .pos      (map_pos_c),
    .wheel_id (map_id_c),
    .dir      (state_q == BWD),
    .ch_out_c (map_out_c)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (!load_en && io.in_valid) state_d = FWD;
      FWD:     if (k_q == K_LAST) state_d = REFL;
      REFL:    state_d = BWD;
      BWD:     if (k_q == '0) state_d = DONE;
      DONE:    if (io.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Combinational outputs: a pending load blocks acceptance.
  always_comb begin
    in_ready_c = (state_q == IDLE) && !load_en;
  end

  // Datapath: positions, in-flight letter, stage index and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_q       <= '0;
      k_q         <= '0;
      x_q         <= '0;
      bypass_q    <= 1'b0;
      out_char_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_en) begin
            pos_q <= pos_load_c;
          end else if (io.in_valid) begin
            x_q      <= io.in_char;
            bypass_q <= nonletter_c;
            k_q      <= '0;
            if (!nonletter_c) pos_q <= pos_step_c;
          end
        end
        FWD: begin
          if (!bypass_q) x_q <= map_out_c;
          if (k_q != K_LAST) k_q <= k_q + KW'(1);
        end
        REFL: begin
          if (!bypass_q) x_q <= reflect_b(x_q);
          k_q <= K_LAST;
        end
        BWD: begin
          if (k_q == '0) begin
            out_char_q  <= bypass_q ? x_q : map_out_c;
            out_valid_q <= 1'b1;
          end else begin
            if (!bypass_q) x_q <= map_out_c;
            k_q <= k_q - KW'(1);
          end
        end
        DONE: begin
          if (io.out_ready) out_valid_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_enigma_rotor_stack.sv
// Directed bench for enigma_rotor_stack (default three-rotor III/II/I order).
module tb_enigma_rotor_stack;
  import enigma_pkg::*;

  localparam int unsigned N = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_en;
  logic [5*N-1:0] load_pos;
  logic [5*N-1:0] rotor_pos;
  int             tests = 0;
  int             fails = 0;

  enigma_rotor_stack_if bus ();

  enigma_rotor_stack #(.NUM_ROTORS(N), .WHEEL_ORDER(9'b000_001_010)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_pos  (load_pos),
    .rotor_pos (rotor_pos),
    .io        (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [5*N-1:0] pos3(input logic [4:0] r2, input logic [4:0] r1,
                                          input logic [4:0] r0);
    return {r2, r1, r0};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [5*N-1:0] v);
    @(negedge clk);
    load_en  = 1'b1;
    load_pos = v;
    @(negedge clk);
    load_en  = 1'b0;
  endtask

  task automatic wait_out();
    int n;
    n = 0;
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_timeout", 32'(bus.out_valid), 32'd1);
  endtask

  // Full transaction with out_ready held high.
  task automatic send(input logic [4:0] c, output logic [4:0] o);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_char   = c;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    wait_out();
    o = bus.out_char;
    @(negedge clk);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] o;
    logic [4:0] c;
    logic [4:0] exp_bdzgo [5];
    logic [4:0] hello [5];
    logic [4:0] ilbda [5];
    logic [4:0] ct [5];

    exp_bdzgo = '{5'd1, 5'd3, 5'd25, 5'd6, 5'd14};
    hello     = '{5'd7, 5'd4, 5'd11, 5'd11, 5'd14};
    ilbda     = '{5'd8, 5'd11, 5'd1, 5'd3, 5'd0};

    rst           = 1'b1;
    load_en       = 1'b0;
    load_pos      = '0;
    bus.in_valid  = 1'b0;
    bus.in_char   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_char",  32'(bus.out_char),  32'd0);
    chk("rst_rotor_pos", 32'(rotor_pos),     32'd0);
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    rst = 1'b0;

    // AAAAA at AAA -> BDZGO, rotor0 ends at F.
    for (int i = 0; i < 5; i++) begin
      send(5'd0, o);
      chk("aaaaa_char", 32'(o), 32'(exp_bdzgo[i]));
    end
    chk("aaaaa_pos", 32'(rotor_pos), 32'(pos3(5'd0, 5'd0, 5'd5)));

    // Double-step from ADU.
    load(pos3(5'd0, 5'd3, 5'd20));
    chk("ds_load", 32'(rotor_pos), 32'(pos3(5'd0, 5'd3, 5'd20)));
    send(5'd0, o);
    chk("ds_adv", 32'(rotor_pos), 32'(pos3(5'd0, 5'd3, 5'd21)));
    send(5'd0, o);
    chk("ds_aew", 32'(rotor_pos), 32'(pos3(5'd0, 5'd4, 5'd22)));
    send(5'd0, o);
    chk("ds_bfx", 32'(rotor_pos), 32'(pos3(5'd1, 5'd5, 5'd23)));

    // Latency and backpressure.
    load(pos3(5'd0, 5'd0, 5'd0));
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_char   = 5'd0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("lat_pos_stepped", 32'(rotor_pos), 32'(pos3(5'd0, 5'd0, 5'd1)));
    chk("lat_in_ready_busy", 32'(bus.in_ready), 32'd0);
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      chk("lat_out_valid", 32'(bus.out_valid), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("lat_char", 32'(bus.out_char), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_out_char",  32'(bus.out_char),  32'd1);
      chk("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_ready", 32'(bus.in_ready),  32'd1);

    // Non-letter bypass, no stepping.
    load(pos3(5'd0, 5'd0, 5'd0));
    send(5'd31, o);
    chk("nonletter_char", 32'(o), 32'd31);
    chk("nonletter_pos",  32'(rotor_pos), 32'd0);

    // HELLO -> ILBDA and back.
    load(pos3(5'd0, 5'd0, 5'd0));
    for (int i = 0; i < 5; i++) begin
      send(hello[i], o);
      ct[i] = o;
      chk("hello_enc", 32'(o), 32'(ilbda[i]));
      chk("hello_no_self", 32'(o != hello[i]), 32'd1);
    end
    load(pos3(5'd0, 5'd0, 5'd0));
    for (int i = 0; i < 5; i++) begin
      c = ct[i];
      send(c, o);
      chk("hello_dec", 32'(o), 32'(hello[i]));
    end

    // Reset while in BWD drops the letter.
    load(pos3(5'd0, 5'd0, 5'd0));
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_char   = 5'd2;
    bus.out_ready = 1'b0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_pos",       32'(rotor_pos),     32'd0);
    chk("midrst_in_ready",  32'(bus.in_ready),  32'd1);
    repeat (10) @(negedge clk);
    chk("midrst_stays_idle", 32'(bus.out_valid), 32'd0);

    // load_en together with in_valid: load wins, letter ignored.
    load_en      = 1'b1;
    load_pos     = pos3(5'd0, 5'd0, 5'd0);
    bus.in_valid = 1'b1;
    bus.in_char  = 5'd0;
    #1;
    chk("ldwin_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    load_en      = 1'b0;
    bus.in_valid = 1'b0;
    chk("ldwin_pos", 32'(rotor_pos), 32'd0);
    repeat (10) @(negedge clk);
    chk("ldwin_no_out", 32'(bus.out_valid), 32'd0);

    // Out-of-range load values are reduced by 26.
    load(pos3(5'd26, 5'd31, 5'd30));
    chk("load_reduce", 32'(rotor_pos), 32'(pos3(5'd0, 5'd5, 5'd4)));

    // load_en while busy is ignored.
    load(pos3(5'd0, 5'd0, 5'd0));
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_char  = 5'd0;
    @(negedge clk);
    bus.in_valid = 1'b0;
    load_en      = 1'b1;
    load_pos     = pos3(5'd9, 5'd9, 5'd9);
    @(negedge clk);
    load_en = 1'b0;
    wait_out();
    chk("busy_load_ignored", 32'(rotor_pos), 32'(pos3(5'd0, 5'd0, 5'd1)));
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/enigma_rotor_stack.md
# enigma_rotor_stack

Parametrised, clocked Enigma scrambler: holds NUM_ROTORS rotor positions, steps them odometer-style (with double-step) on every accepted letter, then enciphers the letter through the forward rotor path, reflector B and the backward rotor path. It replaces the combinational three-rotor chain plus separate rotation engine. Letters enter and leave through valid/ready handshakes, and one letter is in flight at a time. It sits between the keyboard/UART front end and the plugboard/output stage.

## Interface
- NUM_ROTORS, 3, number of rotors (1..8); rotor 0 is the fast rotor on the entry side.
- WHEEL_ORDER, 9'b000_001_010, packed 3-bit wheel IDs, rotor i at bits [3i+2:3i]; 0..4 = I..V. Default is rotor0=III, rotor1=II, rotor2=I.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- load_en  in  1  load load_pos into the rotors (honoured only in IDLE).
- load_pos  in  5*NUM_ROTORS  start positions, rotor i at [5i+4:5i], values 0..25.
- in_valid  in  1  in_char valid.
- in_ready  out  1  block can accept a letter.
- in_char  in  5  letter 0..25 (A..Z); 26..31 are non-letters.
- out_valid  out  1  out_char valid.
- out_ready  in  1  consumer accepts out_char.
- out_char  out  5  enciphered letter.
- rotor_pos  out  5*NUM_ROTORS  current rotor positions, same packing as load_pos.

## Operation
- FSM states: IDLE, FWD, REFL, BWD, DONE. A stage index k counts 0..NUM_ROTORS-1.
- IDLE
  - in_ready = !load_en.
  - If load_en: rotor_pos <= load_pos. Load_pos values above 25 are reduced by 26.
  - Else if in_valid: latch in_char, step the rotors (letters only), k <= 0, go to FWD.
- Stepping, computed from the pre-step positions:
  - Rotor 0 always steps.
  - Rotor i, 0<i<N-1, steps if rotor i-1 is at its notch or rotor i is at its own notch (double-step).
  - Rotor N-1 steps if rotor N-2 is at its notch.
  - Position 25 wraps to 0. Notches: I=Q(16), II=E(4), III=V(21), IV=J(9), V=Z(25).
- Enciphering uses the post-step positions.
  - FWD: one rotor per cycle, k ascending. x <= (Wk[(x+p) mod 26] - p) mod 26. After k=N-1, go to REFL.
  - REFL: x <= reflector B[x], then k <= N-1 and go to BWD.
  - BWD: one rotor per cycle, k descending, using the inverse tables. After k=0, write out_char and go to DONE.
- Non-letters (26..31): no stepping. The character bypasses the mapping but takes the same state path and latency, so out_char = in_char.
- DONE: out_valid=1 and out_char is held. On out_ready, go to IDLE.
- There are no ring settings. Mod-26 arithmetic uses 6-bit add/sub with a single conditional ±26 correction.
- Reset values: state IDLE, all rotor_pos 0, out_char 0, out_valid 0, in_ready 1.

## Timing
- Handshake acceptance happens on the edge where in_valid && in_ready.
- rotor_pos shows the stepped values the cycle after acceptance.
- out_valid rises 2*NUM_ROTORS+1 cycles after the acceptance edge (7 for N=3).
- out_valid stays high until the out_ready edge. in_ready is 0 from acceptance until the cycle after that edge.
- Maximum throughput is one letter per 2*NUM_ROTORS+3 cycles (out_ready held high).
- load_en and in_valid asserted together in IDLE: load wins and the letter is not accepted (in_ready=0).
- load_en outside IDLE is ignored.
- rst mid-operation: the in-flight letter is dropped, the FSM returns to IDLE, positions go to 0 and out_valid is 0 next cycle.
- Outputs are registered (out_char, out_valid, rotor_pos). in_ready is combinational from state and load_en.

## Structure
- Package enigma_pkg holds:
  - ALPHA=26.
  - Forward wiring tables I..V and their inverse tables.
  - Notch positions.
  - Reflector B table.
  - FSM state typedef.
- Sub-module enigma_wheel_map: combinational (char, pos, wheel_id, dir) -> char. One instance, time-shared by FWD/BWD, with reflector lookup inline.

## Test plan
- Default order, reset, positions AAA, in_char A×5 with out_ready=1 -> out_char B,D,Z,G,O. Final rotor_pos rotor0=5 (F), rotor1=0, rotor2=0.
- Double-step: load rotor2=0, rotor1=3, rotor0=20 (ADU), send 3 letters -> rotor_pos sequence ADV, AEW, BFX (rotor2,rotor1,rotor0).
- Latency/backpressure: accept at cycle 0 -> out_valid at cycle 7. Hold out_ready=0 for 5 cycles -> out_char stable, in_ready=0. After the out_ready pulse, in_ready=1 next cycle.
- Non-letter: in_char=31 at AAA -> out_char=31 after 7 cycles, rotor_pos unchanged.
- Reciprocity: encipher HELLO from position 0,0,0, reload 0,0,0, encipher the output -> HELLO. No letter ever maps to itself.
- Reset in BWD plus simultaneous load_en/in_valid in IDLE -> out_valid stays 0, positions 0. Load wins, letter not accepted.
